result_serializer: RTL
======================

// Module: result_serializer
// PURPOSE
// - Downstream stage of the six-result arithmetic datapath (result1..result6, 32 b each).
// - Captures one complete result set with a valid/ready handshake.
// - Streams the set out one word per beat on a single WIDTH-bit valid/ready port, tagged with index and last.
// - Decouples the wide combinational datapath from the narrow consumer bus.
// PARAMETERS
// - WIDTH  32  data width of each result and of out_data
// - IDX_W  3   width of out_idx; must hold 0..6
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      result1..result6 hold a valid set
// - in_ready   out  1      block accepts a set this cycle
// - result1    in   WIDTH  result word 0
// - result2    in   WIDTH  result word 1
// - result3    in   WIDTH  result word 2
// - result4    in   WIDTH  result word 3
// - result5    in   WIDTH  result word 4
// - result6    in   WIDTH  result word 5
// - out_valid  out  1      out_data/out_idx/out_last valid
// - out_ready  in   1      consumer accepts the current beat
// - out_data   out  WIDTH  current word
// - out_idx    out  IDX_W  index of current word (0..5, or 6 for checksum)
// - out_last   out  1      current beat is the final beat of the set
// - busy       out  1      a set is held (state SEND)
// BEHAVIOUR
// - Interface: one clock, clk. Reset rst is asynchronous and active-high.
// - Reset (async assert, sync release): state=IDLE, idx=0, buffer=0.
//   - While rst is high: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, in_ready=0.
// - FSM states:
//   - IDLE: in_ready=1, out_valid=0.
//     - in_valid & in_ready: latch all six words into buf[0..5], idx<=0, go to SEND.
//   - SEND: out_valid=1, out_data=buf[idx], out_idx=idx, busy=1.
//     - out_last=1 when idx==LAST (LAST=5, or 6 with CHECKSUM_EN).
//     - out_valid&out_ready and !out_last: idx<=idx+1.
//     - out_valid&out_ready and out_last: if in_valid&in_ready, reload buf, idx<=0, stay in SEND; else go to IDLE.
// - in_ready = IDLE | (SEND & out_last & out_ready).
//   - This is a combinational path out_ready->in_ready; it gives zero-bubble back-to-back sets.
// - Latency: first beat is valid the cycle after input acceptance.
//   - Throughput is 6 beats per set (7 with CHECKSUM_EN) at out_ready=1.
// - Backpressure: while out_valid & !out_ready, out_data/out_idx/out_last stay stable; idx does not advance.
// - in_valid while in_ready=0 is ignored; changes on result1..6 during SEND do not affect buffered data.
// - out_data=0, out_idx=0, out_last=0 whenever out_valid=0.
// - idx never exceeds LAST; no wrap past LAST.
// - rst mid-stream: the held set is discarded immediately.
//   - After release, IDLE with in_ready=1; the next set starts at idx 0.
// - Arithmetic: none on data except the optional XOR; widths pass through unmodified.
// CONFIGURATION
// - CHECKSUM_EN defined: a 7th beat (idx=6, out_last=1) follows idx 5.
//   - Its data is buf[0]^buf[1]^...^buf[5], computed at capture and stored.
// - CHECKSUM_EN undefined: 6 beats per set, idx 5 is last; no checksum register is built.
// TESTING
// - Single set, results 1..6, out_ready=1 -> beats at cycles 1..6 after accept.
//   - out_data 1..6, out_idx 0..5, out_last only on idx 5; in_ready=1 in cycle 7.
// - Backpressure: set 1..6, out_ready=0 for 3 cycles while idx=2.
//   - out_data=3/out_idx=2 held for 3 cycles, then 4,5,6 follow; no word lost or duplicated.
// - Back-to-back: in_valid held, set 1..6 then set 0xA0..0xA5, out_ready=1.
//   - 12 consecutive beats with no bubble; second set accepted in the cycle of idx-5 handshake.
// - Busy ignore: during SEND of 1..6, drive in_valid=1 with results=0xFFFFFFFF.
//   - Stream stays 1..6; in_ready=0 until the last beat.
// - Reset mid-stream: assert rst after the idx-3 beat.
//   - out_valid=0 in the same cycle; after release, set 7..12 streams 7..12 from idx 0.
// - CHECKSUM_EN: set 1..6 -> 7 beats; beat idx 6 carries 0x00000007 with out_last=1; idx 5 has out_last=0.

Source files
------------

// File: rtl/result_serializer.sv
// Captures six result words with a valid/ready handshake and streams them out one word per beat.
// Optional feature macro: CHECKSUM_EN appends a seventh beat carrying the XOR of the six words.
module result_serializer #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] result1,
  input  logic [WIDTH-1:0] result2,
  input  logic [WIDTH-1:0] result3,
  input  logic [WIDTH-1:0] result4,
  input  logic [WIDTH-1:0] result5,
  input  logic [WIDTH-1:0] result6,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  typedef enum logic {IDLE, SEND} state_t;

`ifdef CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST = IDX_W'(6);
`else
  localparam logic [IDX_W-1:0] LAST = IDX_W'(5);
`endif

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] data_buf [6];
  logic [WIDTH-1:0] sel_word;
  logic             load;

`ifdef CHECKSUM_EN
  logic [WIDTH-1:0] chk;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) data_buf[i] <= '0;
`ifdef CHECKSUM_EN
      chk <= '0;
`endif
    end else if (load) begin
      data_buf[0] <= result1;
      data_buf[1] <= result2;
      data_buf[2] <= result3;
      data_buf[3] <= result4;
      data_buf[4] <= result5;
      data_buf[5] <= result6;
`ifdef CHECKSUM_EN
      chk <= result1 ^ result2 ^ result3 ^ result4 ^ result5 ^ result6;
`endif
    end
  end

  // Word mux; idx never exceeds LAST, so anything else simply reads as zero.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < 6; i++) begin
      if (idx == IDX_W'(i)) sel_word = data_buf[i];
    end
`ifdef CHECKSUM_EN
    if (idx == IDX_W'(6)) sel_word = chk;
`endif
  end

  // in_ready is gated by rst so it reads low for the whole time reset is held.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          load      = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_idx   = idx;
        out_data  = sel_word;
        out_last  = (idx == LAST);
        if (out_ready) begin
          if (idx != LAST) begin
            idx_nxt = idx + IDX_W'(1);
          end else begin
            // Final beat handshake doubles as an accept slot for zero-bubble sets.
            in_ready = !rst;
            if (in_valid) begin
              load    = 1'b1;
              idx_nxt = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
